enum_load_fsm: RTL and testbench

- Parametrised load sequencer built on the team's WAITE/LOAD/READY enumerated FSM.
- Waits for `start`, collects DEPTH words of WIDTH bits over a valid/ready handshake, then presents the packed result until it is consumed.
- Generalises the fixed 3-bit one-hot state type: selectable encoding, exported state, and recovery from illegal encodings (e.g. after a cast from a non-label value).
- Sits between a word-serial source and a wide-word consumer.

---
 rtl/enum_load_fsm.sv | 104 ++++++++++
 tb/tb_enum_load_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/enum_load_fsm.sv
// Load sequencer: gathers DEPTH words of WIDTH bits after start, then holds the packed packet until it is consumed.
// Latency: out_valid DEPTH+1 cycles after start at the earliest; in_ready/out_valid decode straight from the state.
module enum_load_fsm #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ENCODING = 0,
  localparam int SW      = (ENCODING == 1) ? 3 : 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*DEPTH-1:0] out_data,
  output logic [SW-1:0]          state_o,
  output logic                   illegal_o,
  output logic                   err_sticky
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [SW-1:0] WAITE_E = (ENCODING == 1) ? SW'(1) : SW'(0);
  localparam logic [SW-1:0] LOAD_E  = (ENCODING == 1) ? SW'(2) : SW'(1);
  localparam logic [SW-1:0] READY_E = (ENCODING == 1) ? SW'(4) : SW'(2);

  typedef enum logic [SW-1:0] {
    WAITE = WAITE_E,
    LOAD  = LOAD_E,
    READY = READY_E
  } state_t;

  // Kept as a raw vector so that any non-label value it may hold is still decoded.
  logic [SW-1:0]          state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH*DEPTH-1:0] data_q, data_d;
  logic                   err_q;
  logic                   illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAITE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_q | illegal;
    end
  end

  always_comb begin
    state_d = WAITE;
    cnt_d   = cnt_q;
    data_d  = data_q;
    illegal = 1'b0;
    unique case (state_q)
      WAITE: begin
        state_d = WAITE;
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          data_d  = '0;
        end
      end
      LOAD: begin
        state_d = LOAD;
        // abort wins over a word offered in the same cycle
        if (abort) begin
          state_d = WAITE;
          cnt_d   = '0;
        end else if (in_valid) begin
          data_d[int'(cnt_q)*WIDTH +: WIDTH] = in_data;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        state_d = out_ready ? WAITE : READY;
      end
      default: begin
        illegal = 1'b1;
        state_d = WAITE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == READY);
  assign out_data   = data_q;
  assign state_o    = state_q;
  assign illegal_o  = illegal;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_enum_load_fsm.sv
// Scoreboarded directed bench: binary and one-hot instances share stimulus; packets are checked at handshake.
module tb_enum_load_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        b_in_ready, b_out_valid, b_ill, b_err;
  logic [31:0] b_out_data;
  logic [1:0]  b_state;
  logic        o_in_ready, o_out_valid, o_ill, o_err;
  logic [31:0] o_out_data;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  enum_load_fsm #(.WIDTH(8), .DEPTH(4), .ENCODING(0)) u_bin (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .state_o(b_state), .illegal_o(b_ill), .err_sticky(b_err)
  );

  enum_load_fsm #(.WIDTH(8), .DEPTH(4), .ENCODING(1)) u_oh (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data),
    .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
    .state_o(o_state), .illegal_o(o_ill), .err_sticky(o_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_pkt();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_state_bin", b_state, 2'b01);
    chk("load_state_oh", o_state, 3'b010);
  endtask

  task automatic consume();
    for (int i = 0; i < 20 && !b_out_valid; i++) tick();
    chk("out_valid_wait", b_out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("waite_after_consume_bin", b_state, 2'b00);
    chk("waite_after_consume_oh", o_state, 3'b001);
  endtask

  // Monitor: every accepted packet must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && b_out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_packet actual=%0h required=none", b_out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pkt_bin", b_out_data, e);
        chk("pkt_oh_valid", o_out_valid, 1'b1);
        chk("pkt_oh", o_out_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst_in_ready", b_in_ready, 1'b0);
    chk("rst_out_valid", b_out_valid, 1'b0);
    chk("rst_out_data", b_out_data, 32'h0);
    chk("rst_state_bin", b_state, 2'b00);
    chk("rst_state_oh", o_state, 3'b001);
    chk("rst_illegal", b_ill, 1'b0);
    chk("rst_err", o_err, 1'b0);
    rst = 1'b0;
    tick();

    // back-to-back words
    begin_pkt();
    exp_q.push_back(32'h44332211);
    send(8'h11); send(8'h22); send(8'h33);
    chk("in_ready_mid", b_in_ready, 1'b1);
    send(8'h44);
    chk("ready_valid", b_out_valid, 1'b1);
    chk("ready_state_bin", b_state, 2'b10);
    chk("ready_state_oh", o_state, 3'b100);
    chk("ready_in_ready", b_in_ready, 1'b0);
    consume();

    // in_valid toggling
    begin_pkt();
    exp_q.push_back(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      send(8'h11 * (i + 1));
      if (i < 3) begin
        chk("toggle_in_ready_a", b_in_ready, 1'b1);
        in_data = 8'hEE;
        tick();
        chk("toggle_in_ready_b", b_in_ready, 1'b1);
      end
    end
    chk("toggle_ready", b_out_valid, 1'b1);
    consume();

    // abort with a word on the same cycle
    begin_pkt();
    send(8'hAA); send(8'hBB);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_state", b_state, 2'b00);
    chk("abort_in_ready", b_in_ready, 1'b0);
    begin_pkt();
    exp_q.push_back(32'h04030201);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    consume();

    // READY holds against start/abort while out_ready is low
    begin_pkt();
    exp_q.push_back(32'h0D0C0B0A);
    send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      abort = ~i[0];
      tick();
      chk("hold_state", b_state, 2'b10);
      chk("hold_data", b_out_data, 32'h0D0C0B0A);
    end
    start = 1'b0; abort = 1'b0;
    consume();

    // illegal one-hot encoding
    force u_oh.state_q = 3'b011;
    #1;
    chk("illegal_pulse", o_ill, 1'b1);
    chk("illegal_err_pre", o_err, 1'b0);
    chk("illegal_bin_quiet", b_ill, 1'b0);
    release u_oh.state_q;
    tick();
    chk("illegal_recover_state", o_state, 3'b001);
    chk("illegal_pulse_end", o_ill, 1'b0);
    chk("illegal_err_set", o_err, 1'b1);
    tick();
    chk("illegal_err_stays", o_err, 1'b1);
    begin_pkt();
    exp_q.push_back(32'h89ABCDEF);
    send(8'hEF); send(8'hCD); send(8'hAB); send(8'h89);
    chk("post_illegal_ready_oh", o_state, 3'b100);
    consume();
    chk("err_after_pkt", o_err, 1'b1);

    // asynchronous reset mid-LOAD
    begin_pkt();
    send(8'h55); send(8'h66); send(8'h77);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", b_in_ready, 1'b0);
    chk("arst_out_data", b_out_data, 32'h0);
    chk("arst_state_bin", b_state, 2'b00);
    chk("arst_state_oh", o_state, 3'b001);
    chk("arst_err_clear", o_err, 1'b0);
    tick();
    rst = 1'b0;
    begin_pkt();
    exp_q.push_back(32'h78563412);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    consume();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
